// File: rtl/adpll_hop_ctr_pkg.sv
// Shared constants for the ADPLL hop controller: register map, hop state codes,
// STATUS bit positions and the default FCW preset table.
package adpll_hop_ctr_pkg;

  localparam logic [31:0] ADDR_CTRL        = 32'd0;
  localparam logic [31:0] ADDR_STATUS      = 32'd1;
  localparam logic [31:0] ADDR_CH_SEL      = 32'd2;
  localparam logic [31:0] ADDR_TIMEOUT     = 32'd3;
  localparam logic [31:0] ADDR_IRQ_EN      = 32'd4;
  localparam logic [31:0] ADDR_PRESET_BASE = 32'd16;

  localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

  localparam logic [31:0] FCW_BASE = 32'h0262_0000;
  localparam logic [31:0] FCW_STEP = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } hop_state_t;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  localparam int STS_LOCKED = 3;
  localparam int STS_TMO    = 4;
  localparam int STS_LOST   = 5;
  localparam int STS_SAT    = 6;
  localparam int STS_BUSY   = 7;

  // Sticky / IRQ_EN bit order
  localparam int STK_TMO  = 0;
  localparam int STK_LOST = 1;
  localparam int STK_SAT  = 2;

  function automatic logic [31:0] preset_default(input int unsigned idx);
    return FCW_BASE + FCW_STEP * idx;
  endfunction

endpackage

// File: rtl/adpll_lock_mon.sv
// Lock qualification for the WAIT phase: consecutive-lock hold counter and
// saturating timeout counter, both cleared whenever the monitor is inactive.
module adpll_lock_mon
  import adpll_hop_ctr_pkg::*;
#(
  parameter int TMO_W     = 16,
  parameter int LOCK_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             channel_lock,
  input  logic [TMO_W-1:0] timeout,
  output logic             lock_det,
  output logic             tmo_det
);

  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(LOCK_HOLD);

  logic [HOLD_W-1:0] hold_cnt, hold_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_inc;

  // Decisions look at the post-increment value so the transition lands on the
  // N-th qualifying cycle itself; timeout of zero means never time out.
  always_comb begin
    hold_inc = (hold_cnt == HOLD_TGT) ? hold_cnt : hold_cnt + 1'b1;
    tmo_inc  = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
    lock_det = active && channel_lock && (hold_inc >= HOLD_TGT);
    tmo_det  = active && (timeout != '0) && (tmo_inc >= timeout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (!active) begin
      hold_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      hold_cnt <= channel_lock ? hold_inc : '0;
      tmo_cnt  <= tmo_inc;
    end
  end

endmodule

// File: rtl/adpll_hop_ctr.sv
// ADPLL CPU controller: FCW preset bank, hop sequencer (reset, enable, lock
// qualify, monitor), sticky status and maskable level interrupt.
module adpll_hop_ctr
  import adpll_hop_ctr_pkg::*;
#(
  parameter int FCWW      = 26,
  parameter int N_CH      = 8,
  parameter int ADDR_W    = 5,
  parameter int TMO_W     = 16,
  parameter int RST_CYC   = 4,
  parameter int LOCK_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  input  logic              wstrb,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [FCWW-1:0]   fcw,
  output logic              core_rst,
  output logic              core_en,
  input  logic              channel_lock,
  input  logic              channel_sat,
  output logic              irq
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYC - 1);

  hop_state_t        state, state_nxt;
  logic [RC_W-1:0]   rst_cnt;
  logic [CH_W-1:0]   ch_sel;
  logic [TMO_W-1:0]  timeout;
  logic [2:0]        irq_en, irq_en_nxt;
  logic [2:0]        sticky, sticky_nxt, sticky_set, sticky_clr;
  logic [FCWW-1:0]   preset [N_CH];

  logic [31:0]       addr32, rd_mux, status_word;
  logic              wr, rd, sel_preset;
  logic [CH_W-1:0]   preset_idx;
  logic              stop_cmd, start_acc;
  logic              lock_det, tmo_det;
  logic              bus_unused;

  assign bus_unused = &{1'b0, wdata};

  adpll_lock_mon #(
    .TMO_W     (TMO_W),
    .LOCK_HOLD (LOCK_HOLD)
  ) u_lock_mon (
    .clk          (clk),
    .rst          (rst),
    .active       (state == ST_WAIT),
    .channel_lock (channel_lock),
    .timeout      (timeout),
    .lock_det     (lock_det),
    .tmo_det      (tmo_det)
  );

  always_comb begin
    addr32     = 32'(address);
    wr         = valid && wstrb;
    rd         = valid && !wstrb;
    sel_preset = (addr32 >= ADDR_PRESET_BASE) &&
                 (addr32 < ADDR_PRESET_BASE + 32'(N_CH));
    preset_idx = CH_W'(addr32 - ADDR_PRESET_BASE);
    stop_cmd   = wr && (addr32 == ADDR_CTRL) && wdata[CTRL_STOP];
    start_acc  = wr && (addr32 == ADDR_CTRL) && wdata[CTRL_START] && !stop_cmd;
  end

  // STOP outranks START, and both outrank the sequencer's own progress
  always_comb begin
    state_nxt = state;
    if (stop_cmd) begin
      state_nxt = ST_IDLE;
    end else if (start_acc) begin
      state_nxt = ST_RESET;
    end else begin
      case (state)
        ST_RESET:  if (rst_cnt == RST_LAST) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (lock_det)     state_nxt = ST_LOCKED;
          else if (tmo_det) state_nxt = ST_FAIL;
        end
        ST_LOCKED: if (!channel_lock) state_nxt = ST_FAIL;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sticky_set           = '0;
    sticky_set[STK_TMO]  = (state == ST_WAIT)   && (state_nxt == ST_FAIL);
    sticky_set[STK_LOST] = (state == ST_LOCKED) && (state_nxt == ST_FAIL);
    sticky_set[STK_SAT]  = channel_sat && core_en;
    sticky_clr = (wr && (addr32 == ADDR_STATUS)) ? wdata[STS_SAT:STS_TMO] : '0;
    sticky_nxt = (sticky & ~sticky_clr) | sticky_set;
    irq_en_nxt = (wr && (addr32 == ADDR_IRQ_EN)) ? wdata[2:0] : irq_en;
  end

  always_comb begin
    status_word                  = '0;
    status_word[2:0]             = state;
    status_word[STS_LOCKED]      = (state == ST_LOCKED);
    status_word[STS_SAT:STS_TMO] = sticky;
    status_word[STS_BUSY]        = (state == ST_RESET) || (state == ST_WAIT);

    rd_mux = RD_UNMAPPED;
    if (sel_preset) begin
      rd_mux = 32'(preset[preset_idx]);
    end else begin
      case (addr32)
        ADDR_CTRL:    rd_mux = '0;
        ADDR_STATUS:  rd_mux = status_word;
        ADDR_CH_SEL:  rd_mux = 32'(ch_sel);
        ADDR_TIMEOUT: rd_mux = 32'(timeout);
        ADDR_IRQ_EN:  rd_mux = 32'(irq_en);
        default:      rd_mux = RD_UNMAPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rst_cnt  <= '0;
      ready    <= 1'b0;
      rdata    <= '0;
      fcw      <= FCWW'(preset_default(0));
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      irq      <= 1'b0;
      sticky   <= '0;
      ch_sel   <= '0;
      timeout  <= '1;
      irq_en   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        preset[i] <= FCWW'(preset_default(i));
      end
    end else begin
      ready <= valid;
      if (rd) rdata <= rd_mux;

      state <= state_nxt;
      if (start_acc) begin
        rst_cnt <= '0;
        fcw     <= preset[ch_sel];
      end else if ((state == ST_RESET) && (rst_cnt != RST_LAST)) begin
        rst_cnt <= rst_cnt + 1'b1;
      end

      // Core stays in reset from power-up until the first START or STOP
      core_rst <= (state_nxt == ST_RESET) ||
                  (core_rst && (state == ST_IDLE) && (state_nxt == ST_IDLE) && !stop_cmd);
      core_en  <= (state_nxt inside {ST_WAIT, ST_LOCKED, ST_FAIL});

      sticky <= sticky_nxt;
      irq_en <= irq_en_nxt;
      irq    <= |(sticky_nxt & irq_en_nxt);

      if (wr) begin
        if (addr32 == ADDR_CH_SEL)  ch_sel  <= wdata[CH_W-1:0];
        if (addr32 == ADDR_TIMEOUT) timeout <= wdata[TMO_W-1:0];
        if (sel_preset)             preset[preset_idx] <= wdata[FCWW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_adpll_hop_ctr.sv
// Bench for adpll_hop_ctr: register vector table plus hop-sequence scenarios,
// with bus reads checked through an expected-value queue.
module tb_adpll_hop_ctr;

  localparam int FCWW = 26, N_CH = 8, ADDR_W = 5, TMO_W = 16, RST_CYC = 4, LOCK_HOLD = 8;

  localparam logic [ADDR_W-1:0] A_CTRL = 5'd0, A_STATUS = 5'd1, A_CH_SEL = 5'd2,
                                A_TIMEOUT = 5'd3, A_IRQ_EN = 5'd4, A_PRESET = 5'd16;

  logic              clk = 1'b0, rst = 1'b1;
  logic              valid = 1'b0, wstrb = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       wdata = '0;
  logic              channel_lock = 1'b0, channel_sat = 1'b0;
  logic [31:0]       rdata;
  logic              ready;
  logic [FCWW-1:0]   fcw;
  logic              core_rst, core_en, irq;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_rec_t;
  sb_rec_t sb[$];

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       exp;
    string             name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  adpll_hop_ctr #(
    .FCWW(FCWW), .N_CH(N_CH), .ADDR_W(ADDR_W), .TMO_W(TMO_W),
    .RST_CYC(RST_CYC), .LOCK_HOLD(LOCK_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .fcw(fcw), .core_rst(core_rst),
    .core_en(core_en), .channel_lock(channel_lock), .channel_sat(channel_sat), .irq(irq)
  );

  function automatic logic [31:0] preset_ref(input int i);
    return 32'h0262_0000 + 32'h0001_0000 * i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_vec(input logic w, input logic [ADDR_W-1:0] a,
                                   input logic [31:0] d, input logic [31:0] e, input string nm);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Response side: every ready pops one outstanding request
  always @(negedge clk) begin : monitor
    sb_rec_t r;
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: ready=1 with no request outstanding (t=%0t)", $time);
      end else begin
        r = sb.pop_front();
        if (r.chk) check(r.name, rdata, r.exp);
      end
    end
  end

  // Called at a negedge; returns at the next negedge so calls chain back-to-back
  task automatic bus(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] e, input string nm);
    sb_rec_t r;
    valid = 1'b1; wstrb = w; address = a; wdata = d;
    r.chk = c; r.exp = e; r.name = nm;
    sb.push_back(r);
    @(negedge clk);
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'h0, "wr");
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string nm);
    bus(1'b0, a, 32'h0, 1'b1, e, nm);
  endtask

  // Lock went high at the current negedge: still WAIT after 7 cycles, LOCKED after 8
  task automatic lock_qualify(input string tag);
    repeat (LOCK_HOLD - 1) @(negedge clk);
    bus_rd(A_STATUS, 32'h82, {tag, "_pre_lock"});
    bus_rd(A_STATUS, 32'h0B, {tag, "_locked"});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_core_rst", core_rst, 1);
    check("rst_core_en", core_en, 0);
    check("rst_fcw", fcw, preset_ref(0));
    check("rst_irq", irq, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);

    // Register map vectors
    push_vec(0, A_STATUS,  0, 32'h0000_0000, "status_rst");
    push_vec(0, A_CTRL,    0, 32'h0000_0000, "ctrl_rd0");
    push_vec(0, A_CH_SEL,  0, 32'h0000_0000, "chsel_rst");
    push_vec(0, A_TIMEOUT, 0, 32'h0000_FFFF, "timeout_rst");
    push_vec(0, A_IRQ_EN,  0, 32'h0000_0000, "irqen_rst");
    for (int i = 0; i < N_CH; i++)
      push_vec(0, A_PRESET + ADDR_W'(i), 0, preset_ref(i), $sformatf("preset%0d_rst", i));
    push_vec(0, 5'd7,  0, 32'hFFFF_FFFF, "unmapped7");
    push_vec(0, 5'd5,  0, 32'hFFFF_FFFF, "unmapped5");
    push_vec(0, 5'd24, 0, 32'hFFFF_FFFF, "unmapped24");
    push_vec(0, 5'd31, 0, 32'hFFFF_FFFF, "unmapped31");
    push_vec(1, A_CH_SEL,  32'hFF, 0, "");
    push_vec(0, A_CH_SEL,  0, 32'h7, "chsel_width");
    push_vec(1, A_TIMEOUT, 32'h0001_2345, 0, "");
    push_vec(0, A_TIMEOUT, 0, 32'h2345, "timeout_width");
    push_vec(1, A_IRQ_EN,  32'hF, 0, "");
    push_vec(0, A_IRQ_EN,  0, 32'h7, "irqen_width");
    push_vec(1, A_PRESET + 5'd3, 32'hFFFF_FFFF, 0, "");
    push_vec(0, A_PRESET + 5'd3, 0, 32'h03FF_FFFF, "preset3_width");
    push_vec(1, 5'd7, 32'h1234, 0, "");
    push_vec(0, 5'd7, 0, 32'hFFFF_FFFF, "unmapped_wr");
    push_vec(1, A_PRESET + 5'd3, 32'h0265_0000, 0, "");
    push_vec(0, A_PRESET + 5'd3, 0, 32'h0265_0000, "preset3_restore");
    push_vec(1, A_PRESET + 5'd5, 32'h01AB_CDEF, 0, "");
    push_vec(0, A_PRESET + 5'd5, 0, 32'h01AB_CDEF, "preset5_wr");
    push_vec(1, A_CH_SEL,  32'h0, 0, "");
    push_vec(1, A_TIMEOUT, 32'hFFFF, 0, "");
    push_vec(1, A_IRQ_EN,  32'h0, 0, "");
    foreach (vecs[i]) bus(vecs[i].wr, vecs[i].addr, vecs[i].data, !vecs[i].wr, vecs[i].exp, vecs[i].name);

    check("prestart_core_rst", core_rst, 1);
    check("prestart_core_en", core_en, 0);
    check("prestart_fcw", fcw, preset_ref(0));

    // Hop to channel 3 and lock
    bus_wr(A_CH_SEL, 3);
    bus_wr(A_CTRL, 1);
    check("hop_fcw", fcw, 32'h0265_0000);
    cnt = 0;
    for (int i = 0; i < 20 && core_rst; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("core_rst_len", cnt, RST_CYC);
    check("wait_core_en", core_en, 1);
    repeat (10) @(negedge clk);
    channel_lock = 1'b1;
    lock_qualify("hop");
    check("locked_core_en", core_en, 1);
    check("locked_core_rst", core_rst, 0);

    // Lock loss, saturation, W1C
    channel_lock = 1'b0;
    @(negedge clk);
    channel_lock = 1'b1;
    bus_rd(A_STATUS, 32'h24, "lost_status");
    check("fail_core_en", core_en, 1);
    check("lost_irq_masked", irq, 0);
    bus_wr(A_IRQ_EN, 4);
    channel_sat = 1'b1;
    @(negedge clk);
    channel_sat = 1'b0;
    check("sat_irq", irq, 1);
    bus_rd(A_STATUS, 32'h64, "sat_status");
    bus_wr(A_STATUS, 32'h20);
    bus_rd(A_STATUS, 32'h44, "w1c_lost_only");
    check("sat_irq_held", irq, 1);
    channel_sat = 1'b1;
    bus_wr(A_STATUS, 32'h40);
    channel_sat = 1'b0;
    bus_rd(A_STATUS, 32'h44, "set_beats_clear");
    bus_wr(A_STATUS, 32'h70);
    check("w1c_irq_clear", irq, 0);
    bus_rd(A_STATUS, 32'h04, "w1c_all");

    // Timeout after exactly 20 WAIT cycles
    bus_wr(A_IRQ_EN, 1);
    bus_wr(A_TIMEOUT, 20);
    bus_wr(A_CTRL, 1);
    channel_lock = 1'b0;
    repeat (23) @(negedge clk);
    bus_rd(A_STATUS, 32'h82, "tmo_pre");
    bus_rd(A_STATUS, 32'h14, "tmo_fail");
    check("tmo_irq", irq, 1);
    bus_wr(A_STATUS, 32'h10);
    check("tmo_irq_clear", irq, 0);
    bus_rd(A_STATUS, 32'h04, "tmo_cleared");

    // STOP during WAIT; START+STOP together
    bus_wr(A_CTRL, 1);
    repeat (6) @(negedge clk);
    bus_wr(A_CTRL, 3);
    check("stop_core_en", core_en, 0);
    check("stop_core_rst", core_rst, 0);
    bus_rd(A_STATUS, 32'h00, "stop_idle");
    bus_wr(A_CH_SEL, 0);
    bus_wr(A_CTRL, 3);
    check("startstop_fcw", fcw, 32'h0265_0000);
    check("startstop_core_rst", core_rst, 0);

    // Async reset in the middle of RESET with irq raised
    bus_wr(A_TIMEOUT, 3);
    bus_wr(A_CTRL, 1);
    repeat (9) @(negedge clk);
    check("short_tmo_irq", irq, 1);
    bus_rd(A_STATUS, 32'h14, "short_tmo_status");
    bus_wr(A_CH_SEL, 1);
    bus_wr(A_CTRL, 1);
    check("rehop_fcw", fcw, 32'h0263_0000);
    check("rehop_core_rst", core_rst, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_core_rst", core_rst, 1);
    check("arst_core_en", core_en, 0);
    check("arst_fcw", fcw, preset_ref(0));
    check("arst_irq", irq, 0);
    check("arst_ready", ready, 0);
    check("arst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(A_CH_SEL, 0, "arst_chsel");
    bus_rd(A_TIMEOUT, 32'hFFFF, "arst_timeout");
    bus_rd(A_IRQ_EN, 0, "arst_irqen");
    bus_rd(A_PRESET + 5'd5, preset_ref(5), "arst_preset5");
    bus_rd(A_STATUS, 0, "arst_status");
    check("arst_core_rst_held", core_rst, 1);

    // Lock glitch: 7 high, 1 low, then 8 high
    bus_wr(A_CTRL, 1);
    repeat (4) @(negedge clk);
    channel_lock = 1'b1;
    repeat (LOCK_HOLD - 1) @(negedge clk);
    channel_lock = 1'b0;
    @(negedge clk);
    channel_lock = 1'b1;
    lock_qualify("glitch");

    // Lock completes on the timeout cycle
    bus_wr(A_TIMEOUT, 20);
    bus_wr(A_IRQ_EN, 1);
    bus_wr(A_CTRL, 1);
    channel_lock = 1'b0;
    repeat (16) @(negedge clk);
    channel_lock = 1'b1;
    lock_qualify("lock_vs_tmo");
    check("lock_vs_tmo_irq", irq, 0);

    // TIMEOUT=0 never times out
    bus_wr(A_TIMEOUT, 0);
    bus_wr(A_CTRL, 1);
    channel_lock = 1'b0;
    repeat (40) @(negedge clk);
    bus_rd(A_STATUS, 32'h82, "tmo_disabled");
    bus_wr(A_CTRL, 2);
    check("final_stop_core_en", core_en, 0);

    @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
